sdwrseq: RTL and testbench

Multi-block write sequencer between the write-data FIFO and the SD TX frame generator. Given a block count and block size, it forwards words from the FIFO to the frame generator, marks the final word of each block with `M_LAST`, then waits for the card's CRC status token and for DAT0 busy to release before releasing the next block. It reports completion or the first error (bad CRC, timeout, abort) to the command controller.

---
 rtl/sdwrseq.sv | 221 ++++++++++++++++++++++
 tb/tb_sdwrseq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdwrseq.sv
// sdwrseq -- multi-block SD write sequencer.
//
// Sits between the write-data FIFO and the SD TX frame generator. For each
// of i_blocks blocks it passes 2^(lgblk-2) words straight through. It flags
// the final word of each block with M_LAST. It then waits for the card's CRC
// status token, and for DAT0 (busy) to release, before it releases the next
// block. Completion, or the first error, is reported with a one-cycle o_done
// pulse and a held o_err code.
//
// Optional feature: define SDWRSEQ_TIMEOUT_EN to add a wait-state timeout.
// The timeout reports o_err = 2. Without the macro the wait states wait
// forever and LGTIMEOUT is unused.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_start                one-cycle start request (ignored unless idle)
//   i_blocks, i_lgblk      block count, log2 bytes per block (both sampled on start)
//   i_abort                terminate any active sequence
//   S_VALID/S_READY/S_DATA source stream from the write FIFO
//   M_VALID/M_READY/M_DATA/M_LAST  stream to the frame generator
//   i_tx_busy              frame generator still serialising
//   i_crc_stb, i_crc_ok    CRC status token strobe and polarity
//   i_dat0                 DAT0 level (0 = card busy)
//   o_busy, o_done, o_err  status to the command controller
module sdwrseq #(
    parameter int LGTIMEOUT = 23,
    parameter int LGMAXBLK  = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_blocks,
    input  logic [3:0]  i_lgblk,
    input  logic        i_abort,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [31:0] S_DATA,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic [31:0] M_DATA,
    output logic        M_LAST,
    input  logic        i_tx_busy,
    input  logic        i_crc_stb,
    input  logic        i_crc_ok,
    input  logic        i_dat0,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err
);

    localparam int WCW = LGMAXBLK - 1;
    localparam logic [3:0]     LG_MIN   = 4'd2;
    localparam logic [3:0]     LG_MAX   = 4'(LGMAXBLK);
    localparam logic [WCW-1:0] WORD_ONE = WCW'(1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT_CRC,
        ST_WAIT_BUSY
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] word_q, word_d;
    logic [WCW-1:0] words_m1_q, words_m1_d;
    logic [15:0]    blk_q, blk_d;
    logic [1:0]     err_q, err_d;
    logic           done_q, done_d;

    logic [3:0] lg_clamped;
    logic       in_data;
    logic       xfer;
    logic       timeout;

    // Out-of-range block sizes are clamped rather than rejected.
    always_comb begin
        lg_clamped = i_lgblk;
        if (i_lgblk < LG_MIN) begin
            lg_clamped = LG_MIN;
        end else if (i_lgblk > LG_MAX) begin
            lg_clamped = LG_MAX;
        end
    end

    // Pure pass-through while streaming: no buffering, no added latency.
    assign in_data = (state_q == ST_DATA);
    assign M_VALID = in_data && S_VALID;
    assign S_READY = in_data && M_READY;
    assign M_DATA  = S_DATA;
    assign M_LAST  = in_data && (word_q == words_m1_q);
    assign xfer    = M_VALID && M_READY;

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_err  = err_q;

`ifdef SDWRSEQ_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] timer_q, timer_d;

    assign timeout = ((state_q == ST_WAIT_CRC) || (state_q == ST_WAIT_BUSY)) && (&timer_q);

    // Restarts on every state change. Saturation always forces a change,
    // so the counter never wraps.
    always_comb begin
        timer_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_WAIT_CRC) || (state_q == ST_WAIT_BUSY))) begin
            timer_d = timer_q + 1'b1;
        end
    end
`else
    logic unused_lgtimeout;

    assign timeout          = 1'b0;
    assign unused_lgtimeout = (LGTIMEOUT != 0);
`endif

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first; any
        // path that skipped an assignment would otherwise infer a latch.
        state_d    = state_q;
        word_d     = word_q;
        words_m1_d = words_m1_q;
        blk_d      = blk_q;
        err_d      = err_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    err_d = ERR_OK;
                    if (i_blocks != 16'd0) begin
                        blk_d      = i_blocks;
                        words_m1_d = (WORD_ONE << (lg_clamped - LG_MIN)) - WORD_ONE;
                        word_d     = '0;
                        state_d    = ST_DATA;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (word_q == words_m1_q) begin
                        word_d  = '0;
                        state_d = ST_WAIT_CRC;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_WAIT_CRC: begin
                if (i_crc_stb) begin
                    if (i_crc_ok) begin
                        state_d = ST_WAIT_BUSY;
                    end else begin
                        err_d   = ERR_CRC;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                if (i_dat0 && !i_tx_busy) begin
                    blk_d = blk_q - 1'b1;
                    if (blk_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Later assignments win: abort beats timeout beats the normal transition.
        if (timeout) begin
            err_d   = ERR_TIMEOUT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
        if (i_abort && (state_q != ST_IDLE)) begin
            err_d   = ERR_ABORT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            words_m1_q <= '0;
            blk_q      <= '0;
            err_q      <= ERR_OK;
            done_q     <= 1'b0;
`ifdef SDWRSEQ_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            words_m1_q <= words_m1_d;
            blk_q      <= blk_d;
            err_q      <= err_d;
            done_q     <= done_d;
`ifdef SDWRSEQ_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdwrseq.sv
// Directed bench for sdwrseq. Inputs change 1 ns after the rising edge and
// outputs are compared either then (registered outputs) or on the falling
// edge. Every source word is pushed to a scoreboard, together with its
// expected M_LAST, when it is first presented. A falling-edge monitor pops
// and compares on each M_VALID && M_READY transfer.
module tb_sdwrseq;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [15:0] i_blocks;
    logic [3:0]  i_lgblk;
    logic        i_abort;
    logic        S_VALID;
    logic        S_READY;
    logic [31:0] S_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic [31:0] M_DATA;
    logic        M_LAST;
    logic        i_tx_busy;
    logic        i_crc_stb;
    logic        i_crc_ok;
    logic        i_dat0;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_err;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    sdwrseq #(.LGTIMEOUT(4), .LGMAXBLK(12)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_blocks  (i_blocks),
        .i_lgblk   (i_lgblk),
        .i_abort   (i_abort),
        .S_VALID   (S_VALID),
        .S_READY   (S_READY),
        .S_DATA    (S_DATA),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .M_DATA    (M_DATA),
        .M_LAST    (M_LAST),
        .i_tx_busy (i_tx_busy),
        .i_crc_stb (i_crc_stb),
        .i_crc_ok  (i_crc_ok),
        .i_dat0    (i_dat0),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard consumer: one pop per accepted output word.
    always @(negedge i_clk) begin
        if (!i_reset && M_VALID && M_READY) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check("m_data", M_DATA, mon_e.data);
                check("m_last", {31'd0, M_LAST}, {31'd0, mon_e.last});
            end
        end
    end

    task automatic start(input logic [15:0] blocks, input logic [3:0] lg);
        i_start  = 1'b1;
        i_blocks = blocks;
        i_lgblk  = lg;
        next();
        i_start  = 1'b0;
    endtask

    // Present words of an n-word block until 'stop' have been accepted.
    task automatic drive_block(input int n, input int stop, input bit stall);
        int idx   = 0;
        int guard = 0;
        bit pres  = 1'b0;
        while (idx < stop && guard < 5000) begin
            if (!pres) begin
                S_DATA = $urandom;
                sb_q.push_back('{S_DATA, (idx == n - 1)});
                pres = 1'b1;
            end
            S_VALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            M_READY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            if (S_VALID && S_READY) begin
                idx++;
                pres = 1'b0;
            end
            next();
            guard++;
        end
        S_VALID = 1'b0;
        M_READY = 1'b1;
        check("block_words_accepted", 32'(idx), 32'(stop));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Entered in WAIT_CRC: positive token, DAT0 low, optional tx_busy hold, release.
    task automatic finish_block(input int low_cycles, input int tx_cycles, input bit last_blk);
        i_crc_stb = 1'b1;
        i_crc_ok  = 1'b1;
        i_dat0    = 1'b0;
        S_VALID   = 1'b1;
        next();
        i_crc_stb = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            next();
            check("dat0_low_busy", {31'd0, o_busy}, 32'd1);
            check("dat0_low_no_reentry", {31'd0, M_VALID}, 32'd0);
        end
        i_dat0    = 1'b1;
        i_tx_busy = 1'b1;
        for (int i = 0; i < tx_cycles; i++) begin
            next();
            check("tx_busy_hold", {31'd0, M_VALID}, 32'd0);
        end
        i_tx_busy = 1'b0;
        S_VALID   = 1'b0;
        next();
        if (last_blk) begin
            check("final_done", {31'd0, o_done}, 32'd1);
            check("final_err_ok", {30'd0, o_err}, 32'd0);
            check("final_busy_low", {31'd0, o_busy}, 32'd0);
            next();
            check("done_one_cycle", {31'd0, o_done}, 32'd0);
        end else begin
            check("mid_no_done", {31'd0, o_done}, 32'd0);
            check("mid_busy", {31'd0, o_busy}, 32'd1);
        end
    endtask

    initial begin
        bit saw_done;
        int n;

        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_blocks  = '0;
        i_lgblk   = '0;
        i_abort   = 1'b0;
        S_VALID   = 1'b1;
        S_DATA    = '0;
        M_READY   = 1'b1;
        i_tx_busy = 1'b0;
        i_crc_stb = 1'b0;
        i_crc_ok  = 1'b0;
        i_dat0    = 1'b1;
        next();
        next();
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {30'd0, o_err}, 32'd0);
        check("rst_m_valid", {31'd0, M_VALID}, 32'd0);
        check("rst_s_ready", {31'd0, S_READY}, 32'd0);
        check("rst_m_last", {31'd0, M_LAST}, 32'd0);
        i_reset = 1'b0;
        S_VALID = 1'b0;
        next();

        // Single 512-byte block: 128 words, M_LAST only on the last.
        start(16'd1, 4'd9);
        check("start_busy", {31'd0, o_busy}, 32'd1);
        drive_block(128, 128, 1'b0);
        finish_block(20, 0, 1'b1);

        // Three 16-byte blocks with random stalls, tx_busy hold on block 2.
        start(16'd3, 4'd4);
        drive_block(4, 4, 1'b1);
        finish_block(5, 0, 1'b0);
        drive_block(4, 4, 1'b1);
        finish_block(5, 3, 1'b0);
        drive_block(4, 4, 1'b1);
        finish_block(5, 0, 1'b1);

        // lgblk below range clamps to one word per block.
        start(16'd1, 4'd1);
        drive_block(1, 1, 1'b0);
        finish_block(2, 0, 1'b1);

        // CRC failure on block 2 of 4: block 3 is never requested.
        start(16'd4, 4'd4);
        drive_block(4, 4, 1'b1);
        finish_block(3, 0, 1'b0);
        drive_block(4, 4, 1'b1);
        i_crc_stb = 1'b1;
        i_crc_ok  = 1'b0;
        S_VALID   = 1'b1;
        M_READY   = 1'b1;
        next();
        i_crc_stb = 1'b0;
        check("crc_bad_done", {31'd0, o_done}, 32'd1);
        check("crc_bad_err", {30'd0, o_err}, 32'd1);
        check("crc_bad_busy", {31'd0, o_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            next();
            check("crc_bad_s_ready", {31'd0, S_READY}, 32'd0);
        end
        check("crc_bad_err_held", {30'd0, o_err}, 32'd1);
        S_VALID = 1'b0;

        // No token after block 1.
        start(16'd2, 4'd2);
        drive_block(1, 1, 1'b0);
`ifdef SDWRSEQ_TIMEOUT_EN
        n = 0;
        saw_done = 1'b0;
        while (!saw_done && n < 40) begin
            next();
            n++;
            saw_done = o_done;
        end
        check("timeout_done", {31'd0, saw_done}, 32'd1);
        check("timeout_err", {30'd0, o_err}, 32'd2);
        check("timeout_latency_ok", {31'd0, (n >= 15 && n <= 16)}, 32'd1);
`else
        saw_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            next();
            saw_done = saw_done | o_done;
        end
        check("no_timeout_busy", {31'd0, o_busy}, 32'd1);
        check("no_timeout_done", {31'd0, saw_done}, 32'd0);
        i_abort = 1'b1;
        next();
        i_abort = 1'b0;
        check("abort_wait_done", {31'd0, o_done}, 32'd1);
        check("abort_wait_err", {30'd0, o_err}, 32'd3);
`endif
        next();

        // Abort in idle is ignored.
        i_abort = 1'b1;
        next();
        i_abort = 1'b0;
        check("idle_abort_no_done", {31'd0, o_done}, 32'd0);
        check("idle_abort_busy", {31'd0, o_busy}, 32'd0);

        // Abort after word 5 of a 128-word block, then a zero-block start
        // in the same cycle as the abort's o_done.
        start(16'd1, 4'd9);
        drive_block(128, 5, 1'b0);
        i_abort = 1'b1;
        next();
        i_abort = 1'b0;
        S_VALID = 1'b1;
        check("abort_m_valid", {31'd0, M_VALID}, 32'd0);
        check("abort_err", {30'd0, o_err}, 32'd3);
        check("abort_done", {31'd0, o_done}, 32'd1);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        S_VALID = 1'b0;
        start(16'd0, 4'd9);
        check("zero_blk_done", {31'd0, o_done}, 32'd1);
        check("zero_blk_err", {30'd0, o_err}, 32'd0);
        check("zero_blk_busy", {31'd0, o_busy}, 32'd0);
        next();
        check("zero_blk_done_clear", {31'd0, o_done}, 32'd0);

        // Reset while in WAIT_BUSY.
        start(16'd2, 4'd2);
        drive_block(1, 1, 1'b0);
        i_crc_stb = 1'b1;
        i_crc_ok  = 1'b1;
        i_dat0    = 1'b0;
        next();
        i_crc_stb = 1'b0;
        check("pre_reset_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        S_VALID = 1'b1;
        next();
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_done", {31'd0, o_done}, 32'd0);
        check("mid_rst_err", {30'd0, o_err}, 32'd0);
        check("mid_rst_m_valid", {31'd0, M_VALID}, 32'd0);
        check("mid_rst_s_ready", {31'd0, S_READY}, 32'd0);
        check("mid_rst_m_last", {31'd0, M_LAST}, 32'd0);
        i_reset = 1'b0;
        i_dat0  = 1'b1;
        S_VALID = 1'b0;
        next();
        check("post_rst_no_done", {31'd0, o_done}, 32'd0);
        next();
        check("post_rst_still_idle", {31'd0, o_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
